// File: rtl/nibble_serial_adder_ctrl.sv
// Multi-cycle WIDTH-bit adder: one 4-bit carry-select slice is reused LS nibble first.
// Optional subtract mode (extra `sub` port) is enabled by defining NIBBLE_SERIAL_SUB_EN.

module rca_4 (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       ci,
    output logic [3:0] s,
    output logic       co,
    output logic       ovf
);
    logic [2:0] lo;
    logic [2:0] hi0;
    logic [2:0] hi1;
    logic [2:0] hi;

    // Both upper-half sums are formed up front; the lower-half carry only drives a mux.
    assign lo  = {1'b0, a[1:0]} + {1'b0, b[1:0]} + {2'b00, ci};
    assign hi0 = {1'b0, a[3:2]} + {1'b0, b[3:2]};
    assign hi1 = {1'b0, a[3:2]} + {1'b0, b[3:2]} + 3'd1;
    assign hi  = lo[2] ? hi1 : hi0;

    assign s   = {hi[1:0], lo[1:0]};
    assign co  = hi[2];
    assign ovf = (a[3] == b[3]) && (s[3] != a[3]);
endmodule

module nibble_serial_adder_ctrl #(
    parameter int WIDTH = 32  // multiple of 4, at least 8
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] data_operandA,
    input  logic [WIDTH-1:0] data_operandB,
    input  logic             cin,
`ifdef NIBBLE_SERIAL_SUB_EN
    input  logic             sub,
`endif
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             overflow,
    output logic             busy
);
    localparam int N    = WIDTH / 4;
    localparam int IDXW = (N > 1) ? $clog2(N) : 1;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    logic [1:0]       state;
    logic [IDXW-1:0]  idx;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic             carry_q;

    logic [WIDTH-1:0] b_in;
    logic             c_in;
    logic [3:0]       slice_s;
    logic             slice_co;
    logic             slice_ovf;

`ifdef NIBBLE_SERIAL_SUB_EN
    // Subtract as A + ~B + 1; cin is ignored in that mode.
    assign b_in = sub ? ~data_operandB : data_operandB;
    assign c_in = sub | cin;
`else
    assign b_in = data_operandB;
    assign c_in = cin;
`endif

    rca_4 u_slice (
        .a   (a_q[idx*4 +: 4]),
        .b   (b_q[idx*4 +: 4]),
        .ci  (carry_q),
        .s   (slice_s),
        .co  (slice_co),
        .ovf (slice_ovf)
    );

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);
    assign busy      = (state == RUN) || (state == DONE);

    always_ff @(posedge clock) begin
        if (reset) begin
            state    <= IDLE;
            idx      <= '0;
            sum      <= '0;
            cout     <= 1'b0;
            overflow <= 1'b0;
            carry_q  <= 1'b0;
        end else begin
            case (state)
                IDLE: if (in_valid) begin
                    a_q      <= data_operandA;
                    b_q      <= b_in;
                    carry_q  <= c_in;
                    idx      <= '0;
                    sum      <= '0;
                    cout     <= 1'b0;
                    overflow <= 1'b0;
                    state    <= RUN;
                end
                RUN: begin
                    sum[idx*4 +: 4] <= slice_s;
                    carry_q         <= slice_co;
                    // Last write holds the MS-nibble overflow, i.e. the full-width one.
                    overflow        <= slice_ovf;
                    idx             <= idx + 1'b1;
                    if (idx == IDXW'(N - 1)) begin
                        cout  <= slice_co;
                        state <= DONE;
                    end
                end
                DONE: if (out_ready) state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: doc/nibble_serial_adder_ctrl.md
Name: nibble_serial_adder_ctrl

Overview:
Multi-cycle controller that computes a WIDTH-bit add by sequencing a single 4-bit carry-select adder slice (rca_4) over WIDTH/4 clock cycles, least-significant nibble first. The block owns one rca_4 instance, the operand/result registers and the inter-nibble carry register. It sits between an upstream requester and a downstream consumer using valid/ready handshakes. It is the area-saving alternative to a full-width adder in ALU paths that tolerate latency.

Parameters:
WIDTH, 32, operand/result width in bits; must be a multiple of 4 and at least 8.

Ports:
clock  input  1  single clock; all state updates on rising edge
reset  input  1  synchronous, active-high reset
in_valid  input  1  request presents operands
in_ready  output  1  block can accept a request (high only in IDLE)
data_operandA  input  WIDTH  operand A
data_operandB  input  WIDTH  operand B
cin  input  1  carry-in for the LS nibble
out_valid  output  1  result held and valid (high only in DONE)
out_ready  input  1  consumer takes result
sum  output  WIDTH  registered result
cout  output  1  carry out of the MS nibble
overflow  output  1  signed overflow of the full-width add
busy  output  1  high in RUN or DONE

Behaviour:
- States: IDLE, RUN, DONE. Nibble index idx counts 0..N-1, where N = WIDTH/4.
- Reset: on a clock edge with reset=1, the state goes to IDLE and idx to 0. sum, cout, overflow and the carry register all clear to 0. Outputs after reset: in_ready=1, out_valid=0, busy=0. Reset overrides all other inputs and aborts a RUN or DONE in progress with no result delivered.
- IDLE: in_ready=1. On an edge with in_valid=1:
  - latch A, B and cin (into the carry register);
  - set idx=0;
  - clear sum, cout and overflow;
  - go to RUN.
  If in_valid=0 the block stays in IDLE.
- RUN: in_ready=0.
  - The rca_4 slice is driven combinationally with A[4*idx+3:4*idx], B[4*idx+3:4*idx] and the carry register.
  - Each edge: sum[4*idx+3:4*idx] <= slice sum; carry register <= slice carry-out; overflow <= slice overflow; idx <= idx+1.
  - On the edge that writes idx=N-1, cout <= slice carry-out, and the state goes to DONE.
- DONE: out_valid=1. sum, cout and overflow are stable and must not change while out_valid=1.
  - On an edge with out_ready=1, go to IDLE.
  - Otherwise hold indefinitely (backpressure).
- Latency: out_valid rises exactly N cycles after the accepting edge (8 for WIDTH=32). Minimum issue interval is N+2 cycles: accept, N RUN cycles, one DONE cycle with out_ready=1, return to IDLE.
- The DONE-to-IDLE edge does not accept a new request, because in_ready=0 in DONE.
- in_valid while busy is ignored. Operand inputs are sampled only at the accept edge, so changes to data_operandA/B during RUN have no effect.
- Arithmetic:
  - sum = (A + B + cin) mod 2^WIDTH; cout = bit WIDTH of that sum.
  - overflow = 1 iff A[MSB] == B'[MSB] and sum[MSB] != A[MSB], where B' = B (or ~B with SUB_EN and sub=1). This equals the MS-nibble slice overflow.
- No combinational path from in_valid or out_ready to any output other than via registered state. in_ready, out_valid and busy are decoded from state only.

Optional Feature:
Macro NIBBLE_SERIAL_SUB_EN.
- Defined: adds port sub (input, 1), sampled at the accept edge.
  - sub=1: the block latches ~data_operandB and forces the carry register to 1, ignoring cin. Result = A - B; cout=1 means no borrow.
  - sub=0: behaviour is identical to the undefined case.
- Undefined: no sub port; add only. Behaviour is exactly as above.

Test Plan:
- Add with signed overflow: WIDTH=32, A=0x7FFFFFFF, B=0x00000001, cin=0, out_ready=1 → out_valid rises exactly 8 cycles after accept; sum=0x80000000, cout=0, overflow=1.
- Add with wrap: A=0xFFFFFFFF, B=0x00000001, cin=0 → sum=0x00000000, cout=1, overflow=0. Add with cin=1: A=0x0000000F, B=0, cin=1 → sum=0x00000010 (carry crosses the nibble boundary).
- Backpressure: A=0x12345678, B=0x11111111 with out_ready=0 for 5 cycles → out_valid held; sum=0x23456789 stable each cycle; in_valid pulses during this time are ignored. Then out_ready=1 → IDLE next edge, in_ready=1.
- Reset mid-op: accept A=0xFFFFFFFF, B=0xFFFFFFFF, assert reset after 3 RUN cycles → next edge: IDLE, sum=0, cout=0, overflow=0, out_valid never asserted. A new request then completes correctly.
- Back-to-back: two requests with in_valid held high and out_ready=1 → accept edges are exactly 10 cycles apart; both results correct.
- NIBBLE_SERIAL_SUB_EN: A=5, B=7, sub=1 → sum=0xFFFFFFFE, cout=0, overflow=0. A=0x80000000, B=1, sub=1 → sum=0x7FFFFFFF, cout=1, overflow=1.
